alu_op2_sequencer: RTL
======================

Name: alu_op2_sequencer

Overview:
Multi-cycle controller that accepts one RV32I instruction per valid/ready handshake and decodes it into the operand-2 select code and immediate fields for the ALUSrc2 mux. It issues ALU start pulses and waits for ALU completion. Branches are sequenced as two ALU phases: a compare using RS2, then a target add using the branch offset. The block sits between fetch/decode and the ALUSrc2 mux plus ALU in the multi-cycle datapath.

Parameters:
ALU_TIMEOUT, 15, maximum WAIT cycles without alu_done before the operation is aborted.
TO_W, 4, width of the timeout counter.
SEL_W, 5, width of op2_sel; matches the ALUSrc2 OP2 input.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
instr_valid  in  1  instruction offered
instr_ready  out  1  controller can accept an instruction
instr  in  32  RV32I instruction word
op2_sel  out  SEL_W  drives ALUSrc2 OP2
imm_7  out  7  instr[31:25], drives Imm_7
imm_5  out  5  instr[11:7], drives Imm_5
imm_12  out  12  instr[31:20], drives Imm_12
shamt_5  out  5  instr[24:20], drives Shamt_5
imm_20  out  20  instr[31:12], drives Imm_20
alu_start  out  1  one-cycle start pulse to the ALU
alu_phase  out  1  0 = first or only phase, 1 = branch target phase
alu_done  in  1  ALU result valid; must arrive at least 1 cycle after alu_start
op_done  out  1  one-cycle pulse when the instruction completes
illegal  out  1  one-cycle pulse when the opcode or funct field is unsupported
timeout  out  1  one-cycle pulse when the ALU wait is aborted
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low at a clk edge):
  - state IDLE.
  - op2_sel, all immediate fields, alu_start, alu_phase, op_done, illegal, timeout = 0.
  - Counter = 0.
  - instr_ready = (state==IDLE), so it is 1 after the reset edge.
- States and transitions:
  - IDLE: instr_ready=1. When instr_valid is high, latch instr; go to DECODE.
  - DECODE (1 cycle): if illegal, pulse illegal and go to IDLE. Otherwise set op2_sel and alu_phase=0; go to ISSUE.
  - ISSUE (1 cycle): alu_start=1; go to WAIT; clear counter.
  - WAIT: alu_done is sampled only in this state; alu_done during ISSUE is ignored.
    - alu_done on a branch in phase 0: set alu_phase=1, op2_sel=7; go to ISSUE.
    - alu_done otherwise: op_done pulses next cycle; go to IDLE.
    - Counter reaches ALU_TIMEOUT with no done: pulse timeout; go to IDLE; no op_done.
- Latency: accept edge T0 → alu_start in cycle T0+2 → done at T0+2+k (k≥1) → op_done and instr_ready at T0+3+k. A branch adds one more ISSUE+WAIT pass.
- Field outputs are registered at accept and held stable until the next accept.
- op2_sel and alu_phase are held through WAIT.
- op2_sel codes (SEL_W bits, unsigned):
  - 0 RS2, 1 IMM7, 2 IMM5, 3 IMM12, 4 SHAMT5, 5 IMM20, 6 STORE_OFF ({imm_7,imm_5}).
  - 7 BRANCH_OFF, 8 JAL_OFF. All other codes are reserved.
- Decode by opcode instr[6:0]:
  - 0110011 → 0.
  - 0010011 → 4 if funct3 is 001 or 101, else 3.
  - 0000011 and 1100111 → 3.
  - 0100011 → 6.
  - 0110111 and 0010111 → 5.
  - 1100011 → two phases, 0 then 7.
  - 1101111 → 8.
  - Anything else → illegal.
- Illegal shifts: funct3=001 with instr[31:25]≠0000000, or funct3=101 with instr[31:25] not 0000000 or 0100000.
- instr_valid while not IDLE: not accepted, since instr_ready=0.
- Reset mid-operation: the operation is abandoned; no op_done, alu_start or illegal pulse is emitted.
- op_done, illegal and timeout are mutually exclusive and never assert in the same cycle.

Decomposition:
- Package alu_op2_pkg holds:
  - op2_sel code constants (0–8);
  - RV32I opcode constants;
  - FSM state encoding (IDLE, DECODE, ISSUE, WAIT).
- Sub-module alu_op2_decode: combinational instr → {op2_sel, two_phase, illegal}. The FSM and counter live in the top.

Test Plan:
- ADDI x1,x0,-6 (0xFFA00093), alu_done 1 cycle after start → op2_sel=3, imm_12=0xFFA, alu_start at T0+2, op_done at T0+4, then instr_ready=1.
- SLLI x1,x1,5 (0x00509093) → op2_sel=4, shamt_5=5. Then 0x40509093 (bad funct7) → illegal pulse at T0+1, no alu_start, back in IDLE.
- BEQ x1,x2,+8 (0x00208463) → first alu_start with op2_sel=0 and alu_phase=0; second alu_start with op2_sel=7 and alu_phase=1; exactly one op_done.
- SW x2,12(x1) (0x0020A623) → op2_sel=6, imm_7=0, imm_5=0x0C. LUI x1,0xE7 (0x000E70B7) → op2_sel=5, imm_20=0x000E7.
- ADDI with alu_done never asserted → timeout pulse after 15 WAIT cycles, no op_done, busy=0 afterwards.
- BEQ with rst_n low during phase-1 WAIT, and instr_valid held high while busy:
  - outputs return to 0, no op_done;
  - the held instruction is not taken while busy;
  - the next ADDI after reset is accepted and completes normally.

Source files
------------

// File: rtl/alu_op2_pkg.sv
// Shared constants for the ALUSrc2 operand-2 sequencer: select codes, opcodes, FSM states.
package alu_op2_pkg;

  // op2_sel codes driven to the ALUSrc2 mux
  localparam int unsigned SelRs2       = 0;
  localparam int unsigned SelImm7      = 1;
  localparam int unsigned SelImm5      = 2;
  localparam int unsigned SelImm12     = 3;
  localparam int unsigned SelShamt5    = 4;
  localparam int unsigned SelImm20     = 5;
  localparam int unsigned SelStoreOff  = 6;
  localparam int unsigned SelBranchOff = 7;
  localparam int unsigned SelJalOff    = 8;

  // RV32I major opcodes
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StIssue,
    StWait
  } state_t;

endpackage

// File: rtl/alu_op2_decode.sv
// Combinational RV32I decode: picks the operand-2 source and flags two-phase or illegal instrs.
module alu_op2_decode
  import alu_op2_pkg::*;
#(
  parameter int unsigned SEL_W = 5
) (
  input  logic [31:0]      instr,
  output logic [SEL_W-1:0] op2_sel,
  output logic             two_phase,
  output logic             illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Opcode/funct decode; only immediate shifts constrain funct7.
  always_comb begin
    op2_sel   = SEL_W'(SelRs2);
    two_phase = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OpReg: op2_sel = SEL_W'(SelRs2);
      OpImm: begin
        if (funct3 == 3'b001) begin
          op2_sel = SEL_W'(SelShamt5);
          illegal = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          op2_sel = SEL_W'(SelShamt5);
          illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
        end else begin
          op2_sel = SEL_W'(SelImm12);
        end
      end
      OpLoad, OpJalr:  op2_sel = SEL_W'(SelImm12);
      OpStore:         op2_sel = SEL_W'(SelStoreOff);
      OpLui, OpAuipc:  op2_sel = SEL_W'(SelImm20);
      OpBranch: begin
        // Compare against RS2 first; the target add follows with the branch offset.
        op2_sel   = SEL_W'(SelRs2);
        two_phase = 1'b1;
      end
      OpJal:   op2_sel = SEL_W'(SelJalOff);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op2_sequencer.sv
// Multi-cycle controller: accepts one instruction, drives ALUSrc2 select/immediates and
// sequences ALU start/done, with a second pass for branch target computation.
module alu_op2_sequencer
  import alu_op2_pkg::*;
#(
  parameter int unsigned ALU_TIMEOUT = 15,
  parameter int unsigned TO_W        = 4,
  parameter int unsigned SEL_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  output logic [SEL_W-1:0] op2_sel,
  output logic [6:0]       imm_7,
  output logic [4:0]       imm_5,
  output logic [11:0]      imm_12,
  output logic [4:0]       shamt_5,
  output logic [19:0]      imm_20,
  output logic             alu_start,
  output logic             alu_phase,
  input  logic             alu_done,
  output logic             op_done,
  output logic             illegal,
  output logic             timeout,
  output logic             busy
);

  state_t            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]  op2_sel_q, op2_sel_d;
  logic              alu_phase_q, alu_phase_d;
  logic              alu_start_q, alu_start_d;
  logic              op_done_q, op_done_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;

  logic [SEL_W-1:0]  dec_sel;
  logic              dec_two_phase;
  logic              dec_illegal;

  // Decode always looks at the latched word, so its result stays valid through WAIT.
  alu_op2_decode #(
    .SEL_W (SEL_W)
  ) u_decode (
    .instr     (instr_q),
    .op2_sel   (dec_sel),
    .two_phase (dec_two_phase),
    .illegal   (dec_illegal)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    cnt_d       = cnt_q;
    op2_sel_d   = op2_sel_q;
    alu_phase_d = alu_phase_q;
    alu_start_d = 1'b0;
    op_done_d   = 1'b0;
    illegal_d   = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (dec_illegal) begin
          illegal_d = 1'b1;
          state_d   = StIdle;
        end else begin
          op2_sel_d   = dec_sel;
          alu_phase_d = 1'b0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        alu_start_d = 1'b1;
        cnt_d       = '0;
        state_d     = StWait;
      end
      StWait: begin
        if (alu_done) begin
          if (dec_two_phase && !alu_phase_q) begin
            alu_phase_d = 1'b1;
            op2_sel_d   = SEL_W'(SelBranchOff);
            state_d     = StIssue;
          end else begin
            op_done_d = 1'b1;
            state_d   = StIdle;
          end
        end else if (cnt_q == TO_W'(ALU_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      instr_q     <= '0;
      cnt_q       <= '0;
      op2_sel_q   <= '0;
      alu_phase_q <= 1'b0;
      alu_start_q <= 1'b0;
      op_done_q   <= 1'b0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      cnt_q       <= cnt_d;
      op2_sel_q   <= op2_sel_d;
      alu_phase_q <= alu_phase_d;
      alu_start_q <= alu_start_d;
      op_done_q   <= op_done_d;
      illegal_q   <= illegal_d;
      timeout_q   <= timeout_d;
    end
  end

  assign instr_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign op2_sel     = op2_sel_q;
  assign alu_phase   = alu_phase_q;
  assign alu_start   = alu_start_q;
  assign op_done     = op_done_q;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign imm_7       = instr_q[31:25];
  assign imm_5       = instr_q[11:7];
  assign imm_12      = instr_q[31:20];
  assign shamt_5     = instr_q[24:20];
  assign imm_20      = instr_q[31:12];

endmodule
